// File: rtl/ray_transceiver_seq.sv
// ray_transceiver_seq
// ----------------------------------------------------------------------------
// One square of the systolic move-generation array. A start pulse in IDLE
// begins a fixed-length sweep:
//   * an occupied square drives its own origin words (orig_ray / orig_kn);
//   * an empty square forwards sliding-piece words it has latched, sending each
//     one out of the opposite channel with the range field decremented by one;
//   * every square latches the first acceptable word seen on each incoming
//     channel. Words of the occupant's own colour are filtered out.
//
// Ports
//   clk, reset     clock / synchronous active-high reset
//   start          sweep request, sampled in IDLE only
//   piece_reg      occupant of this square (MSB = colour, zero = empty)
//   orig_ray/kn    origin words for this square, channel i at [i*W +: W]
//   ray_in/kn_in   words arriving from neighbours
//   ray_out/kn_out words driven toward neighbours (combinational)
//   ray_move/kn_move  latched arriving words, sticky within a sweep
//   move_valid     per-channel latched flag, ray channels in the low bits
//   capture        a latched word captured an opposite-colour occupant
//   busy / done    high during SWEEP / one-cycle pulse at the end of a sweep
// ----------------------------------------------------------------------------

// Per-channel latch. The first nonzero word that passes the colour filter is
// held until the next sweep start; later words on the channel are ignored.
module ray_transceiver_seq_lane #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,        // sweep start: drop the previous sweep's result
    input  logic         en_i,         // latching allowed (SWEEP)
    input  logic         occupied_i,
    input  logic         colour_i,     // occupant colour
    input  logic [W-1:0] word_i,
    output logic [W-1:0] move_o,
    output logic         vld_o,
    output logic         cap_o         // a latch happened into an occupied square
);
    logic [W-1:0] move_q;
    logic         vld_q;
    logic         blocked;
    logic         hit;

    always_comb begin
        blocked = occupied_i && (word_i[W-1] == colour_i);
        hit     = en_i && !blocked && (word_i != '0) && !vld_q;
        // A latch into an occupied square always has the opposite colour,
        // because same-colour words are blocked above.
        cap_o   = hit && occupied_i;
    end

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            move_q <= '0;
            vld_q  <= 1'b0;
        end else if (hit) begin
            move_q <= word_i;
            vld_q  <= 1'b1;
        end
    end

    assign move_o = move_q;
    assign vld_o  = vld_q;
endmodule

module ray_transceiver_seq #(
    parameter int MOVE_W       = 11,
    parameter int KMOVE_W      = 8,
    parameter int PIECE_W      = 6,
    parameter int RANGE_W      = 3,
    parameter int SWEEP_CYCLES = 8,
    parameter int NUM_RAY      = 8,
    parameter int NUM_KN       = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [PIECE_W-1:0]          piece_reg,
    input  logic [NUM_RAY*MOVE_W-1:0]   orig_ray,
    input  logic [NUM_KN*KMOVE_W-1:0]   orig_kn,
    input  logic [NUM_RAY*MOVE_W-1:0]   ray_in,
    input  logic [NUM_KN*KMOVE_W-1:0]   kn_in,
    output logic [NUM_RAY*MOVE_W-1:0]   ray_out,
    output logic [NUM_KN*KMOVE_W-1:0]   kn_out,
    output logic [NUM_RAY*MOVE_W-1:0]   ray_move,
    output logic [NUM_KN*KMOVE_W-1:0]   kn_move,
    output logic [NUM_RAY+NUM_KN-1:0]   move_valid,
    output logic                        capture,
    output logic                        busy,
    output logic                        done
);
    localparam int CNT_W = (SWEEP_CYCLES > 1) ? $clog2(SWEEP_CYCLES) : 1;
    // Ray word layout: colour, orthogonal slider, diagonal slider, range, payload.
    localparam int ORTH_B = MOVE_W - 2;
    localparam int DIAG_B = MOVE_W - 3;
    localparam int RNG_HI = MOVE_W - 4;
    localparam int RNG_LO = MOVE_W - 3 - RANGE_W;

    // Opposite ray channel for the fixed order U,D,L,R,UL,UR,DL,DR.
    function automatic int opp_ch(input int j);
        case (j)
            0: return 1;
            1: return 0;
            2: return 3;
            3: return 2;
            4: return 7;
            5: return 6;
            6: return 5;
            default: return 4;
        endcase
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             capture_q;

    logic             sweep_start;
    logic             in_sweep;
    logic             occupied;
    logic             colour;

    logic [NUM_RAY-1:0][MOVE_W-1:0]  ray_in_w;
    logic [NUM_RAY-1:0][MOVE_W-1:0]  orig_ray_w;
    logic [NUM_RAY-1:0][MOVE_W-1:0]  ray_move_w;
    logic [NUM_RAY-1:0][MOVE_W-1:0]  ray_out_w;
    logic [NUM_KN-1:0][KMOVE_W-1:0]  kn_in_w;
    logic [NUM_KN-1:0][KMOVE_W-1:0]  kn_move_w;
    logic [NUM_RAY-1:0]              ray_vld;
    logic [NUM_RAY-1:0]              ray_cap;
    logic [NUM_KN-1:0]               kn_vld;
    logic [NUM_KN-1:0]               kn_cap;

    assign sweep_start = (state_q == S_IDLE) && start;
    assign in_sweep    = (state_q == S_SWEEP);
    assign occupied    = (piece_reg != '0);
    assign colour      = piece_reg[PIECE_W-1];

    assign ray_in_w    = ray_in;
    assign orig_ray_w  = orig_ray;
    assign kn_in_w     = kn_in;

    // ------------------------------------------------------------------------
    // Sequencer: IDLE -> SWEEP (SWEEP_CYCLES cycles) -> DONE (1 cycle) -> IDLE
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            capture_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q   <= S_SWEEP;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        capture_q <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    if (|{ray_cap, kn_cap}) capture_q <= 1'b1;
                    if (cnt_q == CNT_W'(SWEEP_CYCLES - 1)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Ray channels: latch, plus forwarding out of the opposite channel
    // ------------------------------------------------------------------------
    for (genvar j = 0; j < NUM_RAY; j++) begin : g_ray
        localparam int OJ  = opp_ch(j);
        localparam int SLB = (j < 4) ? ORTH_B : DIAG_B;

        logic [MOVE_W-1:0] src;
        logic [MOVE_W-1:0] fwd;
        logic              fwd_ok;

        ray_transceiver_seq_lane #(.W(MOVE_W)) u_lane (
            .clk       (clk),
            .reset     (reset),
            .clr_i     (sweep_start),
            .en_i      (in_sweep),
            .occupied_i(occupied),
            .colour_i  (colour),
            .word_i    (ray_in_w[j]),
            .move_o    (ray_move_w[j]),
            .vld_o     (ray_vld[j]),
            .cap_o     (ray_cap[j])
        );

        // The word leaving channel j is the one that arrived on the opposite
        // channel (it keeps travelling in the same direction). Uses the
        // registered copy, so a same-cycle latch does not affect this output.
        always_comb begin
            src    = ray_move_w[OJ];
            fwd_ok = (src != '0) && src[SLB] && (src[RNG_HI:RNG_LO] != '0);
            fwd    = src;
            fwd[RNG_HI:RNG_LO] = src[RNG_HI:RNG_LO] - 1'b1;

            if (!in_sweep)
                ray_out_w[j] = '0;
            else if (occupied)
                ray_out_w[j] = orig_ray_w[j];
            else if (fwd_ok)
                ray_out_w[j] = fwd;
            else
                ray_out_w[j] = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Knight channels: latch only; knights never pass through a square
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < NUM_KN; k++) begin : g_kn
        ray_transceiver_seq_lane #(.W(KMOVE_W)) u_lane (
            .clk       (clk),
            .reset     (reset),
            .clr_i     (sweep_start),
            .en_i      (in_sweep),
            .occupied_i(occupied),
            .colour_i  (colour),
            .word_i    (kn_in_w[k]),
            .move_o    (kn_move_w[k]),
            .vld_o     (kn_vld[k]),
            .cap_o     (kn_cap[k])
        );
    end

    assign kn_out     = (in_sweep && occupied) ? orig_kn : '0;
    assign ray_out    = ray_out_w;
    assign ray_move   = ray_move_w;
    assign kn_move    = kn_move_w;
    assign move_valid = {kn_vld, ray_vld};
    assign capture    = capture_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_ray_transceiver_seq.sv
module tb_ray_transceiver_seq;
    localparam int MOVE_W  = 11;
    localparam int KMOVE_W = 8;
    localparam int PIECE_W = 6;
    localparam int NUM_RAY = 8;
    localparam int NUM_KN  = 8;

    localparam logic [NUM_RAY*MOVE_W-1:0] ORAY = 88'h12_3456_789A_BCDE_F013_5779;
    localparam logic [NUM_KN*KMOVE_W-1:0] OKN  = 64'h0123_4567_89AB_CDEF;

    logic                        clk = 1'b0;
    logic                        reset, start;
    logic [PIECE_W-1:0]          piece_reg;
    logic [NUM_RAY*MOVE_W-1:0]   orig_ray, ray_in, ray_out, ray_move;
    logic [NUM_KN*KMOVE_W-1:0]   orig_kn, kn_in, kn_out, kn_move;
    logic [NUM_RAY+NUM_KN-1:0]   move_valid;
    logic                        capture, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ray_transceiver_seq dut (
        .clk(clk), .reset(reset), .start(start), .piece_reg(piece_reg),
        .orig_ray(orig_ray), .orig_kn(orig_kn), .ray_in(ray_in), .kn_in(kn_in),
        .ray_out(ray_out), .kn_out(kn_out), .ray_move(ray_move), .kn_move(kn_move),
        .move_valid(move_valid), .capture(capture), .busy(busy), .done(done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ray(input int c, input logic [MOVE_W-1:0] w);
        ray_in[c*MOVE_W +: MOVE_W] = w;
    endtask

    task automatic set_kn(input int c, input logic [KMOVE_W-1:0] w);
        kn_in[c*KMOVE_W +: KMOVE_W] = w;
    endtask

    // Bounded wait for the done pulse, then one more cycle back into IDLE.
    task automatic run_to_done(input string tag);
        int k;
        k = 0;
        while (!done && k < 20) begin
            step();
            k++;
        end
        chk(tag, done, 1'b1);
        step();
    endtask

    initial begin
        int nb, nd, di;
        reset = 1'b1; start = 1'b0; piece_reg = '0;
        orig_ray = ORAY; orig_kn = OKN; ray_in = '0; kn_in = '0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Reset state
        chk("rst_busy",  busy, 1'b0);
        chk("rst_done",  done, 1'b0);
        chk("rst_mv",    move_valid, 16'h0);
        chk("rst_cap",   capture, 1'b0);
        chk("rst_rmove", ray_move, '0);
        chk("rst_kmove", kn_move, '0);
        chk("rst_rout",  ray_out, '0);

        // Handshake: 8 busy cycles, then one done; start during busy ignored
        start = 1'b1;
        step();
        start = 1'b0;
        nb = 0; nd = 0; di = -1;
        for (int i = 0; i < 12; i++) begin
            if (busy) nb++;
            if (done) begin nd++; di = i; end
            start = (i == 2);
            step();
        end
        start = 1'b0;
        chk("hs_busy_cycles", nb, 8);
        chk("hs_done_count",  nd, 1);
        chk("hs_done_index",  di, 8);
        chk("hs_idle_busy",   busy, 1'b0);

        // Pass-through in an empty square
        piece_reg = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("pt_busy",      busy, 1'b1);
        chk("pt_rout_pre",  ray_out, '0);
        chk("pt_kout_zero", kn_out, '0);
        set_ray(0, 11'h275);    // U, orthogonal, range 3
        set_ray(2, 11'h203);    // L, orthogonal, range 0
        set_ray(4, 11'h147);    // UL, diagonal, range 2
        step();
        chk("pt_D_fwd",     ray_out[1*MOVE_W +: MOVE_W], 11'h255);
        chk("pt_R_range0",  ray_out[3*MOVE_W +: MOVE_W], 11'h000);
        chk("pt_DR_fwd",    ray_out[7*MOVE_W +: MOVE_W], 11'h127);
        chk("pt_mv",        move_valid, 16'h0015);
        ray_in = '0;
        set_ray(0, 11'h2AA);
        step();
        chk("pt_sticky",    ray_move[0*MOVE_W +: MOVE_W], 11'h275);
        chk("pt_D_hold",    ray_out[1*MOVE_W +: MOVE_W], 11'h255);
        ray_in = '0;
        run_to_done("pt_done");
        chk("pt_idle_rout", ray_out, '0);
        chk("pt_idle_hold", ray_move[0*MOVE_W +: MOVE_W], 11'h275);
        chk("pt_idle_mv",   move_valid, 16'h0015);

        // Collision filter, occupied emission, knights
        piece_reg = 6'b100101;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("col_mv_clr",  move_valid, 16'h0);
        chk("col_rout",    ray_out, ORAY);
        chk("col_kout",    kn_out, OKN);
        set_ray(0, 11'h675);    // same colour as occupant
        step();
        chk("col_same_mv",  move_valid[0], 1'b0);
        chk("col_same_cap", capture, 1'b0);
        set_ray(0, 11'h275);    // opposite colour
        step();
        chk("col_opp_mv",   move_valid[0], 1'b1);
        chk("col_opp_cap",  capture, 1'b1);
        chk("col_opp_word", ray_move[0*MOVE_W +: MOVE_W], 11'h275);
        ray_in = '0;
        set_kn(2, 8'h15);       // opposite colour knight
        set_kn(3, 8'h81);       // same colour knight
        step();
        chk("kn_mv",        move_valid[15:8], 8'h04);
        chk("kn_word",      kn_move[2*KMOVE_W +: KMOVE_W], 8'h15);
        set_kn(2, 8'h33);
        set_kn(3, 8'h00);
        step();
        chk("kn_sticky",    kn_move[2*KMOVE_W +: KMOVE_W], 8'h15);
        kn_in = '0;
        piece_reg = '0;
        #1;
        chk("kn_empty_out", kn_out, '0);
        chk("kn_still_busy", busy, 1'b1);
        run_to_done("col_done");
        chk("col_idle_cap", capture, 1'b1);

        // Slider class mismatch: diagonal word on U must not reach D
        piece_reg = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("mm_cap_clr", capture, 1'b0);
        chk("mm_mv_clr",  move_valid, 16'h0);
        set_ray(0, 11'h147);
        step();
        chk("mm_mv",      move_valid[0], 1'b1);
        chk("mm_D_out",   ray_out[1*MOVE_W +: MOVE_W], 11'h000);
        ray_in = '0;
        run_to_done("mm_done");

        // Reset in the middle of a sweep
        piece_reg = 6'b100101;
        set_ray(0, 11'h275);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("mr_pre_cap", capture, 1'b1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        ray_in = '0;
        piece_reg = '0;
        chk("mr_busy",  busy, 1'b0);
        chk("mr_mv",    move_valid, 16'h0);
        chk("mr_rmove", ray_move, '0);
        chk("mr_cap",   capture, 1'b0);
        chk("mr_done",  done, 1'b0);
        nd = 0;
        repeat (12) begin
            step();
            if (done) nd++;
        end
        chk("mr_no_done", nd, 0);
        chk("mr_busy_end", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
